// File: rtl/cmd_seq_uart_if.sv
// Command sequencer bus: control request, ROM port, UART port
// and response buffer readout, seen from the sequencer (slave).
interface cmd_seq_uart_if #(
    parameter int AW         = 5,
    parameter int LW         = 4,
    parameter int RESP_DEPTH = 8
);
    localparam int CW  = $clog2(RESP_DEPTH) + 1;
    localparam int RAW = $clog2(RESP_DEPTH);

    logic          send;
    logic [AW-1:0] cmd_start;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_dout;
    logic [7:0]    tx_data;
    logic          trmt;
    logic          tx_done;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          clr_rx_rdy;
    logic          busy;
    logic          done;
    logic          resp_ok;
    logic          timeout_err;
    logic [CW-1:0] resp_cnt;
    logic          resp_ovf;
    logic [RAW-1:0] resp_raddr;
    logic [7:0]    resp_rdata;

    modport master (
        output send, cmd_start, cmd_len, rom_dout, tx_done,
        output rx_rdy, rx_data, resp_raddr,
        input  rom_addr, tx_data, trmt, clr_rx_rdy, busy, done,
        input  resp_ok, timeout_err, resp_cnt, resp_ovf, resp_rdata
    );

    modport slave (
        input  send, cmd_start, cmd_len, rom_dout, tx_done,
        input  rx_rdy, rx_data, resp_raddr,
        output rom_addr, tx_data, trmt, clr_rx_rdy, busy, done,
        output resp_ok, timeout_err, resp_cnt, resp_ovf, resp_rdata
    );
endinterface

// File: rtl/cmd_seq_uart.sv
// Streams a command from a synchronous ROM to a UART, then captures
// the reply up to a terminator byte, with timeout and command retry.
module cmd_seq_uart #(
    parameter int         AW          = 5,
    parameter int         LW          = 4,
    parameter logic [7:0] TERM_BYTE   = 8'h0A,
    parameter int         RESP_DEPTH  = 8,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         MAX_RETRY   = 2
) (
    input logic           clk,
    input logic           rst_n,
    cmd_seq_uart_if.slave bus
);
    localparam int CW  = $clog2(RESP_DEPTH) + 1;
    localparam int RAW = $clog2(RESP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYC);
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]  DEPTH  = CW'(RESP_DEPTH);
    localparam logic [RTW-1:0] RMAX   = RTW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, ROM_WAIT, XMIT, TX_WAIT, RESP, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  rom_addr_q, rom_addr_d;
    logic [AW-1:0]  start_q, start_d;
    logic [AW-1:0]  last_q, last_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [RTW-1:0] retry_q, retry_d;
    logic [CW-1:0]  resp_cnt_q, resp_cnt_d;
    logic           resp_ovf_q, resp_ovf_d;
    logic           resp_ok_q, resp_ok_d;
    logic           timeout_err_q, timeout_err_d;
    logic           trmt_q, trmt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           buf_we;
    logic [RAW-1:0] buf_waddr;
    logic [7:0]     resp_buf [RESP_DEPTH];

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        start_d       = start_q;
        last_d        = last_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        resp_cnt_d    = resp_cnt_q;
        resp_ovf_d    = resp_ovf_q;
        resp_ok_d     = resp_ok_q;
        timeout_err_d = timeout_err_q;
        buf_we        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.send) begin
                    start_d    = bus.cmd_start;
                    last_d     = bus.cmd_start + AW'(bus.cmd_len);
                    rom_addr_d = bus.cmd_start;
                    resp_cnt_d = '0;
                    resp_ovf_d = 1'b0;
                    retry_d    = '0;
                    state_d    = ROM_WAIT;
                end
            end
            ROM_WAIT: state_d = XMIT;
            XMIT:     state_d = TX_WAIT;
            TX_WAIT: begin
                if (bus.tx_done) begin
                    if (rom_addr_q == last_q) begin
                        timer_d = '0;
                        state_d = RESP;
                    end else begin
                        rom_addr_d = rom_addr_q + AW'(1);
                        state_d    = ROM_WAIT;
                    end
                end
            end
            RESP: begin
                timer_d = timer_q + TW'(1);
                // A received byte takes priority over an expiring timer
                if (bus.rx_rdy) begin
                    timer_d = '0;
                    if (bus.rx_data == TERM_BYTE) begin
                        resp_ok_d     = 1'b1;
                        timeout_err_d = 1'b0;
                        state_d       = DONE;
                    end else if (resp_cnt_q < DEPTH) begin
                        buf_we     = 1'b1;
                        resp_cnt_d = resp_cnt_q + CW'(1);
                    end else begin
                        resp_ovf_d = 1'b1;
                    end
                end else if (timer_q == T_LAST) begin
                    timer_d = '0;
                    if (retry_q < RMAX) begin
                        retry_d    = retry_q + RTW'(1);
                        rom_addr_d = start_q;
                        resp_cnt_d = '0;
                        state_d    = ROM_WAIT;
                    end else begin
                        resp_ok_d     = 1'b0;
                        timeout_err_d = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        trmt_d = (state_d == XMIT);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign buf_waddr = resp_cnt_q[RAW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rom_addr_q    <= '0;
            start_q       <= '0;
            last_q        <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
            resp_cnt_q    <= '0;
            resp_ovf_q    <= 1'b0;
            resp_ok_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            trmt_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            start_q       <= start_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            resp_cnt_q    <= resp_cnt_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_ok_q     <= resp_ok_d;
            timeout_err_q <= timeout_err_d;
            trmt_q        <= trmt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            resp_buf[buf_waddr] <= bus.rx_data;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.tx_data     = bus.rom_dout;
    assign bus.trmt        = trmt_q;
    assign bus.clr_rx_rdy  = bus.rx_rdy;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.resp_ok     = resp_ok_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.resp_cnt    = resp_cnt_q;
    assign bus.resp_ovf    = resp_ovf_q;
    assign bus.resp_rdata  = resp_buf[bus.resp_raddr];
endmodule

// File: doc/cmd_seq_uart.md
Name: cmd_seq_uart

Overview:
- Parametrised command sequencer that streams a multi-byte command from an external synchronous command ROM to a UART transmitter, then collects the peripheral's reply bytes into an internal response buffer until a terminator byte arrives.
- Adds configurable address/length widths, a response timeout with automatic command retry, and response capture with overflow flagging.
- Sits between the top-level control FSM and the UART; the UART and the ROM are instantiated outside this block.

Parameters:
- AW, 5, ROM address width; addresses wrap modulo 2^AW.
- LW, 4, cmd_len width.
- TERM_BYTE, 8'h0A, response terminator value.
- RESP_DEPTH, 8, response buffer entries (power of 2).
- TIMEOUT_CYC, 100000, inter-byte response timeout in clk cycles (>=2).
- MAX_RETRY, 2, command re-sends allowed after a timeout before failing.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- send  in  1  start request; sampled only in IDLE.
- cmd_start  in  AW  first ROM address of the command.
- cmd_len  in  LW  number of bytes minus one (bytes sent = cmd_len+1).
- rom_addr  out  AW  ROM address; ROM returns rom_dout one cycle after the address.
- rom_dout  in  8  ROM data.
- tx_data  out  8  byte to UART; equals rom_dout.
- trmt  out  1  one-cycle UART transmit strobe.
- tx_done  in  1  UART byte-sent indication.
- rx_rdy  in  1  UART byte available.
- rx_data  in  8  received byte.
- clr_rx_rdy  out  1  asserted combinationally whenever rx_rdy=1 (every RX byte is consumed).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- resp_ok  out  1  qualified by done: terminator received.
- timeout_err  out  1  qualified by done: retries exhausted.
- resp_cnt  out  $clog2(RESP_DEPTH)+1  bytes stored for the last response; the terminator is not stored.
- resp_ovf  out  1  more than RESP_DEPTH non-terminator bytes were received.
- resp_raddr  in  $clog2(RESP_DEPTH)  response buffer read address.
- resp_rdata  out  8  combinational read of buffer[resp_raddr].

Behaviour:
- Reset is asynchronous, active-low, on rst_n; the clock is clk.
- Reset values: state=IDLE; rom_addr=0, trmt=0, busy=0, done=0, resp_ok=0, timeout_err=0, resp_cnt=0, resp_ovf=0, retry count=0. Buffer contents are not reset.
- IDLE: on send, latch start=cmd_start and last=cmd_start+cmd_len (AW-bit, wraps). Set rom_addr=cmd_start, clear resp_cnt, resp_ovf and the retry count, then go to ROM_WAIT. resp_ok and timeout_err hold their last values while in IDLE.
- ROM_WAIT: one-cycle wait; go to XMIT.
- XMIT: assert trmt for one cycle; go to TX_WAIT.
- TX_WAIT: on tx_done:
  - if rom_addr==last, clear the timer and go to RESP;
  - otherwise rom_addr+1 (wrapping) and go to ROM_WAIT.
- Latency: send to first trmt is 2 cycles.
- RESP: the timer increments each cycle.
  - rx_rdy with rx_data==TERM_BYTE: go to DONE with resp_ok=1.
  - rx_rdy with another byte: if resp_cnt<RESP_DEPTH, write buffer[resp_cnt] and increment resp_cnt; else set resp_ovf. In both cases clear the timer.
  - timer reaching TIMEOUT_CYC-1 without rx_rdy:
    - if retries<MAX_RETRY: retries+1, rom_addr=start, clear resp_cnt, go to ROM_WAIT;
    - else go to DONE with timeout_err=1.
- DONE: done=1 and busy=1 for one cycle; then go to IDLE.
- RX bytes arriving outside RESP are cleared and discarded.
- send asserted while busy is ignored.
- A send in the same cycle as done is ignored.
- rx_rdy and a timeout in the same cycle: the byte wins.
- Reset mid-command: return to IDLE immediately; no further trmt pulses.
- cmd_start+cmd_len past 2^AW-1 wraps through address 0.

Test Plan:
- cmd_start=3, cmd_len=2, ROM[3..5]=11,22,33; reply 41,42,0A -> trmt three times with tx_data 11,22,33; done with resp_ok=1, resp_cnt=2, buffer[0..1]=41,42.
- cmd_start=30, cmd_len=3 (AW=5) -> rom_addr sequence 30,31,0,1; four bytes sent.
- No reply, TIMEOUT_CYC=50, MAX_RETRY=2 -> command sent 3 times in full; done with timeout_err=1, resp_ok=0.
- RESP_DEPTH=8, reply of 10 bytes then 0A -> resp_cnt=8, resp_ovf=1, resp_ok=1.
- send pulsed mid-transfer, plus a stray rx_rdy during TX_WAIT -> no restart; clr_rx_rdy pulses; byte not stored.
- rst_n asserted during TX_WAIT -> busy=0, trmt=0; a following send starts cleanly at the new cmd_start.
